uart_tx_arbiter: RTL and testbench

- Shares one multi-byte UART transmitter (uart_data_tx: data / send_en / baud_set in, tx_done / uart_state out) between NUM_REQ requesters.
- Round-robin grant; launches exactly one frame per grant and waits for completion; returns a per-requester ack pulse.
- Sits between the requester logic and the transmitter instance; it is the only driver of the transmitter's inputs.

---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ requesters.
// Each grant launches exactly one frame and is closed by an ack pulse or a timeout_err pulse.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [2:0]                    baud_cfg,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          timeout_err,
    output logic                          grant_valid,
    output logic [IDX_W-1:0]              grant_idx,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_send_en,
    output logic [2:0]                    tx_baud_set,
    input  logic                          tx_done,
    input  logic                          tx_busy,
    output logic [1:0]                    dbg_state
);

    // Handshake: req is a level held until its ack; tx_send_en is a one-cycle launch
    // pulse; tx_done is a one-cycle completion pulse and only counts while in WAIT.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_REQ - 1);

    state_t                  state, state_d;
    logic [IDX_W-1:0]        ptr, ptr_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic [NUM_REQ-1:0]      ack_d;
    logic                    timeout_err_d;
    logic                    grant_valid_d;
    logic [IDX_W-1:0]        grant_idx_d;
    logic [DATA_WIDTH-1:0]   tx_data_d;
    logic                    tx_send_en_d;
    logic [2:0]              tx_baud_set_d;

    logic                    found;
    logic [IDX_W-1:0]        winner;
    logic [IDX_W-1:0]        cand;
    logic [DATA_WIDTH-1:0]   words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign dbg_state = state;

    // First set request bit scanning upward from the slot after the last grant.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d       = state;
        ptr_d         = ptr;
        cnt_d         = cnt;
        ack_d         = '0;
        timeout_err_d = 1'b0;
        grant_valid_d = grant_valid;
        grant_idx_d   = grant_idx;
        tx_data_d     = tx_data;
        tx_send_en_d  = 1'b0;
        tx_baud_set_d = tx_baud_set;

        case (state)
            ST_IDLE: begin
                cnt_d = '0;
                if (found && !tx_busy) begin
                    state_d       = ST_SEND;
                    grant_valid_d = 1'b1;
                    grant_idx_d   = winner;
                    tx_data_d     = words[winner];
                    tx_baud_set_d = baud_cfg;
                end
            end
            ST_SEND: begin
                cnt_d        = '0;
                tx_send_en_d = 1'b1;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion beats a coincident timeout; the requester still gets its ack.
                if (tx_done) begin
                    ack_d         = NUM_REQ'(1) << grant_idx;
                    ptr_d         = grant_idx;
                    grant_valid_d = 1'b0;
                    cnt_d         = '0;
                    state_d       = ST_IDLE;
                end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    ptr_d         = grant_idx;
                    grant_valid_d = 1'b0;
                    cnt_d         = '0;
                    state_d       = ST_IDLE;
                end else if (cnt != '1) begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ptr         <= PTR_RESET;
            cnt         <= '0;
            ack         <= '0;
            timeout_err <= 1'b0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            tx_data     <= '0;
            tx_send_en  <= 1'b0;
            tx_baud_set <= '0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            cnt         <= cnt_d;
            ack         <= ack_d;
            timeout_err <= timeout_err_d;
            grant_valid <= grant_valid_d;
            grant_idx   <= grant_idx_d;
            tx_data     <= tx_data_d;
            tx_send_en  <= tx_send_en_d;
            tx_baud_set <= tx_baud_set_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: transaction-level model checked every cycle,
// a launch-order scoreboard, and a transmitter stub that answers tx_send_en.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int DW      = 32;
    localparam int TMO     = 50;
    localparam int W       = IDX_W + DW;

    logic                   clk;
    logic                   reset;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*DW-1:0]  req_data;
    logic [2:0]             baud_cfg;
    logic [NUM_REQ-1:0]     ack;
    logic                   timeout_err;
    logic                   grant_valid;
    logic [IDX_W-1:0]       grant_idx;
    logic [DW-1:0]          tx_data;
    logic                   tx_send_en;
    logic [2:0]             tx_baud_set;
    logic                   tx_done;
    logic                   tx_busy;
    logic [1:0]             dbg_state;

    logic [DW-1:0] word [NUM_REQ];
    logic          stub_en, stub_busy, stub_done, force_busy, inj_done;
    int            stub_cnt, done_lat;
    int            pend [NUM_REQ];
    int            ack_cnt [NUM_REQ];
    int            cyc, send_cyc, to_cyc, to_cnt;
    logic [NUM_REQ-1:0] last_ack;

    // Model view of the registered outputs for the current cycle.
    logic [NUM_REQ-1:0] e_ack;
    logic               e_to, e_gv, e_send;
    logic [IDX_W-1:0]   e_idx;
    logic [DW-1:0]      e_data;
    logic [2:0]         e_baud;
    int                 m_ptr, m_age;
    bit                 m_fresh;

    logic [W-1:0] exp_q [$];
    int           n_checks, n_fail;

    assign req_data = {word[3], word[2], word[1], word[0]};
    assign tx_done  = stub_done | inj_done;
    assign tx_busy  = stub_busy | force_busy;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .baud_cfg(baud_cfg),
        .ack(ack), .timeout_err(timeout_err), .grant_valid(grant_valid),
        .grant_idx(grant_idx), .tx_data(tx_data), .tx_send_en(tx_send_en),
        .tx_baud_set(tx_baud_set), .tx_done(tx_done), .tx_busy(tx_busy),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected finish before 1 ms");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        e_ack = '0; e_to = 1'b0; e_gv = 1'b0; e_send = 1'b0;
        e_idx = '0; e_data = '0; e_baud = '0;
        m_ptr = NUM_REQ - 1; m_age = 0; m_fresh = 1'b1;
    endtask

    // Advance the model by one clock using this cycle's inputs.
    // m_age counts cycles since the grant became visible: 1 = launch pending, >=2 = waiting.
    task automatic model_advance();
        int  c;
        bit  hit;
        e_ack = '0; e_to = 1'b0; e_send = 1'b0;
        if (!e_gv) begin
            if (req != '0 && !tx_busy) begin
                hit = 1'b0;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    c = (m_ptr + k) % NUM_REQ;
                    if (!hit && req[c]) begin
                        hit   = 1'b1;
                        e_idx = IDX_W'(c);
                    end
                end
                e_gv    = 1'b1;
                e_data  = req_data[int'(e_idx)*DW +: DW];
                e_baud  = baud_cfg;
                m_age   = 1;
                m_fresh = 1'b0;
            end
        end else if (m_age == 1) begin
            e_send = 1'b1;
            m_age  = 2;
        end else if (tx_done) begin
            e_ack = NUM_REQ'(1) << e_idx;
            m_ptr = e_idx;
            e_gv  = 1'b0;
        end else if (m_age - 1 == TMO) begin
            e_to  = 1'b1;
            m_ptr = e_idx;
            e_gv  = 1'b0;
        end else begin
            m_age++;
        end
    endtask

    // One clock: compare at negedge, then drive requesters and stub just after posedge.
    task automatic step();
        logic [W-1:0] exp_e;
        @(negedge clk);
        if (reset) model_reset();
        check("ack", ack, e_ack);
        check("timeout_err", timeout_err, e_to);
        check("grant_valid", grant_valid, e_gv);
        check("grant_idx", grant_idx, e_idx);
        check("tx_send_en", tx_send_en, e_send);
        if (e_gv || m_fresh) begin
            check("tx_data", tx_data, e_data);
            check("tx_baud_set", tx_baud_set, e_baud);
        end
        if (tx_send_en) begin
            check("sb_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_e = exp_q.pop_front();
                check("sb_grant_idx", grant_idx, exp_e[W-1:DW]);
                check("sb_tx_data", tx_data, exp_e[DW-1:0]);
            end
        end
        if (!reset) model_advance();

        @(posedge clk);
        #1;
        cyc++;
        if (ack != '0) last_ack = ack;
        if (tx_send_en) send_cyc = cyc;
        if (timeout_err) begin
            to_cyc = cyc;
            to_cnt++;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack[i]) begin
                ack_cnt[i]++;
                if (pend[i] > 0) pend[i]--;
            end
            req[i] = (pend[i] > 0) && !ack[i];
        end
        stub_done = 1'b0;
        if (stub_cnt != 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                stub_done = 1'b1;
                stub_busy = 1'b0;
            end
        end else if (tx_send_en && stub_en) begin
            stub_cnt  = done_lat;
            stub_busy = 1'b1;
        end
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic expect_frame(input int idx);
        exp_q.push_back({IDX_W'(idx), word[idx]});
    endtask

    task automatic wait_grant(input string name, input int bound);
        for (int i = 0; i < bound && !grant_valid; i++) step();
        check(name, grant_valid, 1);
    endtask

    task automatic wait_send(input string name, input int bound);
        for (int i = 0; i < bound && !tx_send_en; i++) step();
        check(name, tx_send_en, 1);
    endtask

    task automatic wait_acks(input string name, input int idx, input int target, input int bound);
        for (int i = 0; i < bound && ack_cnt[idx] < target; i++) step();
        check(name, ack_cnt[idx], target);
    endtask

    initial begin
        reset = 1'b1; req = '0; baud_cfg = '0;
        word = '{32'h0, 32'h0, 32'h0, 32'h0};
        stub_en = 1'b1; stub_busy = 1'b0; stub_done = 1'b0;
        force_busy = 1'b0; inj_done = 1'b0; stub_cnt = 0; done_lat = 3;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = 0;
            ack_cnt[i] = 0;
        end
        cyc = 0; send_cyc = 0; to_cyc = 0; to_cnt = 0; last_ack = '0;
        n_checks = 0; n_fail = 0;
        model_reset();

        step_n(3);
        check("rst_ack", ack, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_send_en", tx_send_en, 0);
        check("rst_tx_baud_set", tx_baud_set, 0);
        reset = 1'b0;
        step_n(2);

        // Round robin with all four requesting; requester 0 comes back for a second frame.
        word = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        baud_cfg = 3'd2;
        pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
        expect_frame(0); expect_frame(1); expect_frame(2); expect_frame(3); expect_frame(0);
        wait_acks("rr_ack0", 0, 2, 200);
        check("rr_ack1", ack_cnt[1], 1);
        check("rr_ack2", ack_cnt[2], 1);
        check("rr_ack3", ack_cnt[3], 1);
        check("rr_last_ack", last_ack, 4'b0001);

        // Single request; data and baud changed after grant must not reach the frame.
        word[0] = 32'h0123_4567; baud_cfg = 3'd4; pend[0] = 1;
        expect_frame(0);
        wait_grant("single_grant", 20);
        check("single_grant_idx", grant_idx, 0);
        word[0] = 32'hDEAD_BEEF; baud_cfg = 3'd7;
        step();
        check("single_send_en", tx_send_en, 1);
        check("single_tx_data", tx_data, 32'h0123_4567);
        check("single_baud", tx_baud_set, 4);
        wait_acks("single_ack", 0, 3, 40);
        check("single_ack_mask", last_ack, 4'b0001);
        step();
        check("single_gv_low", grant_valid, 0);

        // Transmitter busy blocks the grant until it falls.
        force_busy = 1'b1; pend[2] = 1;
        expect_frame(2);
        step_n(10);
        check("busy_no_grant", grant_valid, 0);
        force_busy = 1'b0;
        step();
        check("busy_grant_valid", grant_valid, 1);
        check("busy_grant_idx", grant_idx, 2);
        wait_acks("busy_ack", 2, 2, 40);

        // Timeout: stub stays silent for requester 3, then requester 1 goes next.
        stub_en = 1'b0; pend[1] = 1; pend[3] = 1;
        expect_frame(3);
        for (int i = 0; i < 100 && to_cnt == 0; i++) step();
        check("to_seen", to_cnt, 1);
        check("to_latency", to_cyc - send_cyc, 50);
        check("to_ack_now", ack, 0);
        check("to_no_ack3", ack_cnt[3], 1);
        stub_en = 1'b1;
        expect_frame(1); expect_frame(3);
        wait_acks("to_next_ack1", 1, 2, 60);
        wait_acks("to_retry_ack3", 3, 2, 60);

        // Requester 1 drops req during WAIT; the frame completes and ack still pulses.
        pend[1] = 1; done_lat = 6;
        expect_frame(1);
        wait_send("abandon_send", 20);
        pend[1] = 0;
        wait_acks("abandon_ack", 1, 3, 40);
        check("abandon_ack_mask", last_ack, 4'b0010);
        done_lat = 3;

        // Stale tx_done in IDLE and in SEND is ignored.
        step_n(2);
        inj_done = 1'b1;
        step();
        inj_done = 1'b0;
        step();
        check("stale_idle_gv", grant_valid, 0);
        check("stale_idle_state", dbg_state, 0);
        word[0] = 32'h0BAD_F00D; pend[0] = 1;
        expect_frame(0);
        wait_grant("stale_send_grant", 20);
        inj_done = 1'b1;
        step();
        inj_done = 1'b0;
        check("stale_send_en", tx_send_en, 1);
        check("stale_send_no_ack", ack, 0);
        wait_acks("stale_send_ack", 0, 4, 40);
        step_n(5);
        check("stale_single_ack", ack_cnt[0], 4);

        // Reset in WAIT: outputs clear at once, in-flight frame blocks until tx_busy falls.
        pend[2] = 1; done_lat = 20;
        expect_frame(2);
        wait_send("mid_rst_send", 20);
        step_n(2);
        reset = 1'b1;
        #1;
        check("mid_rst_gv", grant_valid, 0);
        check("mid_rst_send_en", tx_send_en, 0);
        check("mid_rst_idx", grant_idx, 0);
        check("mid_rst_data", tx_data, 0);
        check("mid_rst_baud", tx_baud_set, 0);
        pend[2] = 0;
        step_n(3);
        reset = 1'b0;
        done_lat = 3; pend[0] = 1;
        expect_frame(0);
        wait_grant("post_rst_grant", 40);
        check("post_rst_idx", grant_idx, 0);
        check("post_rst_no_ack2", ack_cnt[2], 2);
        wait_acks("post_rst_ack", 0, 5, 60);

        step_n(3);
        check("sb_drained", exp_q.size(), 0);
        check("timeout_total", to_cnt, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
